// File: rtl/seq_alu.sv
// Clocked, parametrised ALU with a valid/ready operand handshake and registered result/flags.
// MUL (shift-add) and DIV (restoring) iterate one bit per cycle; everything else takes one cycle.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           command,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid,
  output logic                 zero,
  output logic                 div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned W2    = 2 * WIDTH;

  localparam logic [3:0] CmdAdd  = 4'd0;
  localparam logic [3:0] CmdInc  = 4'd1;
  localparam logic [3:0] CmdSub  = 4'd2;
  localparam logic [3:0] CmdDec  = 4'd3;
  localparam logic [3:0] CmdMul  = 4'd4;
  localparam logic [3:0] CmdDiv  = 4'd5;
  localparam logic [3:0] CmdShl  = 4'd6;
  localparam logic [3:0] CmdShr  = 4'd7;
  localparam logic [3:0] CmdAnd  = 4'd8;
  localparam logic [3:0] CmdOr   = 4'd9;
  localparam logic [3:0] CmdInv  = 4'd10;
  localparam logic [3:0] CmdNand = 4'd11;
  localparam logic [3:0] CmdNor  = 4'd12;
  localparam logic [3:0] CmdXor  = 4'd13;
  localparam logic [3:0] CmdXnor = 4'd14;
  localparam logic [3:0] CmdBuf  = 4'd15;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]      acc_q, acc_d;
  logic [W2-1:0]      op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic               is_div_q, is_div_d;
  logic [W2-1:0]      out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               zero_q, zero_d;
  logic               dbz_q, dbz_d;

  // Single-cycle datapath
  logic [WIDTH:0]     sub_w, dec_w;
  logic [W2-1:0]      a_ext, b_ext, alu_res;

  assign sub_w = {1'b0, a} - {1'b0, b};
  assign dec_w = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
  assign a_ext = {{WIDTH{1'b0}}, a};
  assign b_ext = {{WIDTH{1'b0}}, b};

  always_comb begin
    alu_res = '0;
    case (command)
      CmdAdd:  alu_res = a_ext + b_ext;
      CmdInc:  alu_res = a_ext + {{(W2-1){1'b0}}, 1'b1};
      CmdSub:  alu_res = {{(WIDTH-1){1'b0}}, sub_w};
      CmdDec:  alu_res = {{(WIDTH-1){1'b0}}, dec_w};
      CmdDiv:  alu_res = {a, {WIDTH{1'b1}}};  // only reached with b == 0
      CmdShl:  alu_res = {{(WIDTH-1){1'b0}}, a, 1'b0};
      CmdShr:  alu_res = a_ext >> 1;
      CmdAnd:  alu_res = {{WIDTH{1'b0}}, a & b};
      CmdOr:   alu_res = {{WIDTH{1'b0}}, a | b};
      CmdInv:  alu_res = {{WIDTH{1'b0}}, ~a};
      CmdNand: alu_res = {{WIDTH{1'b0}}, ~(a & b)};
      CmdNor:  alu_res = {{WIDTH{1'b0}}, ~(a | b)};
      CmdXor:  alu_res = {{WIDTH{1'b0}}, a ^ b};
      CmdXnor: alu_res = {{WIDTH{1'b0}}, ~(a ^ b)};
      CmdBuf:  alu_res = a_ext;
      default: alu_res = '0;
    endcase
  end

  // Iterative step. MUL: acc = product, op1 = shifting multiplicand, op2 = shifting multiplier.
  // DIV: acc = {remainder, dividend/quotient}, op1[WIDTH-1:0] = divisor.
  logic [W2-1:0]      mul_acc_nxt, div_acc_nxt, step_acc;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;

  assign mul_acc_nxt = acc_q + (op2_q[0] ? op1_q : '0);
  assign div_shift   = acc_q[W2-1:WIDTH-1];
  assign div_ge      = div_shift >= {1'b0, op1_q[WIDTH-1:0]};
  // Remainder stays below the divisor, so WIDTH bits of the difference are exact.
  assign div_rem     = div_ge ? (div_shift[WIDTH-1:0] - op1_q[WIDTH-1:0]) : div_shift[WIDTH-1:0];
  assign div_acc_nxt = {div_rem, acc_q[WIDTH-2:0], div_ge};
  assign step_acc    = is_div_q ? div_acc_nxt : mul_acc_nxt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    is_div_d    = is_div_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (command == CmdMul || (command == CmdDiv && b != '0)) begin
            is_div_d = (command == CmdDiv);
            acc_d    = a_ext;
            op1_d    = b_ext;
            op2_d    = (command == CmdDiv) ? '0 : b;
            if (command == CmdMul) begin
              acc_d = '0;
              op1_d = a_ext;
            end
            cnt_d   = CNT_W'(WIDTH);
            state_d = StBusy;
          end else begin
            out_d       = alu_res;
            out_valid_d = 1'b1;
            zero_d      = (alu_res == '0);
            dbz_d       = (command == CmdDiv);
          end
        end
      end
      StBusy: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (!is_div_q) begin
          op1_d = op1_q << 1;
          op2_d = op2_q >> 1;
        end
        if (cnt_q == CNT_W'(1)) begin
          out_d       = step_acc;
          out_valid_d = 1'b1;
          zero_d      = (step_acc == '0);
          dbz_d       = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      is_div_q    <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      is_div_q    <= is_div_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed table, multi-cycle corner sequences, exhaustive
// small-operand sweep and random ops at WIDTH=8, plus WIDTH=16 spot and random checks.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v8 = 1'b0, rdy8, ov8, z8, d8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  c8 = '0;
  logic [15:0] out8;

  logic        v16 = 1'b0, rdy16, ov16, z16, d16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  c16 = '0;
  logic [31:0] out16;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8), .command(c8),
    .out(out8), .out_valid(ov8), .zero(z8), .div_by_zero(d8)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16), .command(c16),
    .out(out16), .out_valid(ov16), .zero(z16), .div_by_zero(d16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference model straight from the command definitions.
  function automatic longint unsigned model(input int w, input longint unsigned x,
                                            input longint unsigned y, input logic [3:0] c);
    longint unsigned m = (64'd1 << w) - 1;
    longint unsigned top = 64'd1 << w;
    case (c)
      4'd0:  return x + y;
      4'd1:  return x + 1;
      4'd2:  return ((x - y) & m) | ((x < y) ? top : 64'd0);
      4'd3:  return ((x - 1) & m) | ((x == 0) ? top : 64'd0);
      4'd4:  return x * y;
      4'd5:  return (y == 0) ? ((x << w) | m) : (((x % y) << w) | (x / y));
      4'd6:  return x << 1;
      4'd7:  return x >> 1;
      4'd8:  return x & y;
      4'd9:  return x | y;
      4'd10: return ~x & m;
      4'd11: return ~(x & y) & m;
      4'd12: return ~(x | y) & m;
      4'd13: return x ^ y;
      4'd14: return ~(x ^ y) & m;
      default: return x;
    endcase
  endfunction

  task automatic judge(input string nm, input int w, input longint unsigned x,
                       input longint unsigned y, input logic [3:0] c, input bit seen,
                       input int lat, input longint unsigned got, input logic gz, input logic gd);
    longint unsigned exp = model(w, x, y, c);
    int exp_lat = (c == 4'd4 || (c == 4'd5 && y != 0)) ? w + 1 : 1;
    chk({nm, " seen"}, seen, 1);
    if (seen) begin
      chk({nm, " out"}, got, exp);
      chk({nm, " lat"}, lat, exp_lat);
      chk({nm, " zero"}, gz, exp == 0);
      chk({nm, " dbz"}, gd, c == 4'd5 && y == 0);
    end
  endtask

  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic [3:0] c,
                       output bit seen, output int lat, output logic [15:0] got,
                       output logic gz, output logic gd);
    seen = 0;
    lat = 0;
    @(negedge clk);
    a8 = x; b8 = y; c8 = c; v8 = 1'b1;
    @(posedge clk);
    #1 v8 = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ov8) seen = 1;
    end
    got = out8; gz = z8; gd = d8;
    @(negedge clk);
    chk("pulse8", ov8, 0);
  endtask

  task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic [3:0] c,
                        output bit seen, output int lat, output logic [31:0] got,
                        output logic gz, output logic gd);
    seen = 0;
    lat = 0;
    @(negedge clk);
    a16 = x; b16 = y; c16 = c; v16 = 1'b1;
    @(posedge clk);
    #1 v16 = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (ov16) seen = 1;
    end
    got = out16; gz = z16; gd = d16;
    @(negedge clk);
    chk("pulse16", ov16, 0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  cmd;
    logic [15:0] exp;
    int          lat;
    logic        zero;
    logic        dbz;
  } vec_t;

  initial begin
    vec_t        vecs[12];
    bit          seen;
    int          lat;
    logic [15:0] g8;
    logic [31:0] g16;
    logic        gz, gd;
    int          lowc, nv;
    bit          up;

    vecs[0]  = '{8'd200, 8'd100, 4'd0,  16'h012C, 1, 1'b0, 1'b0};
    vecs[1]  = '{8'd5,   8'd10,  4'd2,  16'h01FB, 1, 1'b0, 1'b0};
    vecs[2]  = '{8'hAA,  8'hAA,  4'd13, 16'h0000, 1, 1'b1, 1'b0};
    vecs[3]  = '{8'd255, 8'd255, 4'd4,  16'hFE01, 9, 1'b0, 1'b0};
    vecs[4]  = '{8'd200, 8'd7,   4'd5,  16'h041C, 9, 1'b0, 1'b0};
    vecs[5]  = '{8'd0,   8'd0,   4'd3,  16'h01FF, 1, 1'b0, 1'b0};
    vecs[6]  = '{8'd255, 8'd0,   4'd1,  16'h0100, 1, 1'b0, 1'b0};
    vecs[7]  = '{8'h81,  8'd0,   4'd6,  16'h0102, 1, 1'b0, 1'b0};
    vecs[8]  = '{8'h81,  8'd0,   4'd7,  16'h0040, 1, 1'b0, 1'b0};
    vecs[9]  = '{8'h0F,  8'd0,   4'd10, 16'h00F0, 1, 1'b0, 1'b0};
    vecs[10] = '{8'hFF,  8'hFF,  4'd11, 16'h0000, 1, 1'b1, 1'b0};
    vecs[11] = '{8'd13,  8'd0,   4'd5,  16'h0DFF, 1, 1'b0, 1'b1};

    #1;
    chk("rst out8", out8, 0);
    chk("rst ov8", ov8, 0);
    chk("rst zero8", z8, 0);
    chk("rst dbz8", d8, 0);
    chk("rst rdy8", rdy8, 1);
    chk("rst rdy16", rdy16, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      send8(vecs[i].a, vecs[i].b, vecs[i].cmd, seen, lat, g8, gz, gd);
      chk($sformatf("tbl%0d seen", i), seen, 1);
      chk($sformatf("tbl%0d out", i), g8, vecs[i].exp);
      chk($sformatf("tbl%0d lat", i), lat, vecs[i].lat);
      chk($sformatf("tbl%0d zero", i), gz, vecs[i].zero);
      chk($sformatf("tbl%0d dbz", i), gd, vecs[i].dbz);
    end

    // Back-to-back single-cycle ops
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd10; c8 = 4'd2; v8 = 1'b1;
    @(negedge clk);
    chk("b2b sub valid", ov8, 1);
    chk("b2b sub out", out8, 16'h01FB);
    chk("b2b sub zero", z8, 0);
    chk("b2b dbz cleared", d8, 0);
    a8 = 8'hAA; b8 = 8'hAA; c8 = 4'd13;
    @(negedge clk);
    chk("b2b xor valid", ov8, 1);
    chk("b2b xor out", out8, 0);
    chk("b2b xor zero", z8, 1);
    v8 = 1'b0;
    @(negedge clk);
    chk("b2b end pulse", ov8, 0);

    // MUL with a second request held during BUSY
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd255; c8 = 4'd4; v8 = 1'b1;
    @(posedge clk);
    #1 a8 = 8'd1; b8 = 8'd2; c8 = 4'd0;
    lowc = 0;
    up = 0;
    for (int k = 0; k < 20 && !up; k++) begin
      @(negedge clk);
      if (rdy8) up = 1;
      else begin
        lowc++;
        chk("held busy no valid", ov8, 0);
      end
    end
    chk("held busy cycles", lowc, 8);
    chk("held mul valid", ov8, 1);
    chk("held mul out", out8, 16'hFE01);
    @(negedge clk);
    chk("held add valid", ov8, 1);
    chk("held add out", out8, 16'h0003);
    v8 = 1'b0;

    // Reset in the middle of a MUL
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd255; c8 = 4'd4; v8 = 1'b1;
    @(posedge clk);
    #1 v8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-rst busy", rdy8, 0);
    rst = 1'b1;
    #1;
    chk("mid-rst out", out8, 0);
    chk("mid-rst ov", ov8, 0);
    chk("mid-rst zero", z8, 0);
    chk("mid-rst dbz", d8, 0);
    chk("mid-rst rdy", rdy8, 1);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (15) begin
      @(negedge clk);
      if (ov8) nv++;
    end
    chk("aborted mul silent", nv, 0);
    send8(8'd1, 8'd1, 4'd0, seen, lat, g8, gz, gd);
    judge("post-rst add", 8, 1, 1, 4'd0, seen, lat, g8, gz, gd);
    chk("post-rst add out", g8, 16'h0002);

    // Exhaustive small-operand sweep
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 16; c++) begin
          send8(8'(x), 8'(y), 4'(c), seen, lat, g8, gz, gd);
          judge($sformatf("sweep c=%0d a=%0d b=%0d", c, x, y), 8, x, y, 4'(c),
                seen, lat, g8, gz, gd);
        end

    // Random full-range operands
    for (int i = 0; i < 300; i++) begin
      logic [7:0] x = 8'($urandom_range(0, 255));
      logic [7:0] y = 8'($urandom_range(0, 255));
      logic [3:0] c = 4'($urandom_range(0, 15));
      if (($urandom & 7) == 0) y = 8'd0;
      send8(x, y, c, seen, lat, g8, gz, gd);
      judge($sformatf("rand8 c=%0d a=%0h b=%0h", c, x, y), 8, x, y, c, seen, lat, g8, gz, gd);
    end

    // WIDTH=16 spot checks
    send16(16'hFFFF, 16'hFFFF, 4'd4, seen, lat, g16, gz, gd);
    chk("w16 mul out", g16, 32'hFFFE0001);
    chk("w16 mul lat", lat, 17);
    judge("w16 mul", 16, 16'hFFFF, 16'hFFFF, 4'd4, seen, lat, g16, gz, gd);
    send16(16'hFFFF, 16'h0001, 4'd0, seen, lat, g16, gz, gd);
    chk("w16 add carry", g16, 32'h00010000);
    send16(16'h1234, 16'h0000, 4'd5, seen, lat, g16, gz, gd);
    chk("w16 div0 out", g16, 32'h1234FFFF);
    chk("w16 div0 dbz", gd, 1);
    send16(16'hFFFF, 16'h00FF, 4'd5, seen, lat, g16, gz, gd);
    judge("w16 div", 16, 16'hFFFF, 16'h00FF, 4'd5, seen, lat, g16, gz, gd);
    for (int i = 0; i < 100; i++) begin
      logic [15:0] x = 16'($urandom);
      logic [15:0] y = 16'($urandom);
      logic [3:0]  c = 4'($urandom_range(0, 15));
      send16(x, y, c, seen, lat, g16, gz, gd);
      judge($sformatf("rand16 c=%0d a=%0h b=%0h", c, x, y), 16, x, y, c,
            seen, lat, g16, gz, gd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Clocked, parametrised successor of the team's 8-bit combinational ALU. It keeps the same 16-command encoding and generalises operand width to WIDTH. Operands are accepted through a valid/ready handshake and results are registered. MUL and DIV run as iterative multi-cycle operations (shift-add and restoring division). It adds zero and divide-by-zero status flags, and sits between a register file or test sequencer and result capture logic.

Parameters:
WIDTH, 8, operand width in bits (minimum 2). Result width is 2*WIDTH.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived, not overridden).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands and command present
in_ready  output  1  block can accept; a transfer occurs when in_valid && in_ready at a rising edge
a  input  WIDTH  operand A (unsigned)
b  input  WIDTH  operand B (unsigned)
command  input  4  operation select, encoding below
out  output  2*WIDTH  registered result; holds until the next result
out_valid  output  1  one-cycle pulse when out and flags update
zero  output  1  registered; 1 when the new out == 0
div_by_zero  output  1  registered; 1 when the result is a DIV with b == 0

Behaviour:
- Reset (asynchronous, takes effect immediately): out=0, out_valid=0, zero=0, div_by_zero=0, in_ready=1, FSM=IDLE, counter=0. Reset mid-MUL/DIV aborts the operation with no out_valid; the aborted operation is never reported.
- Encoding: 0 ADD, 1 INC, 2 SUB, 3 DEC, 4 MUL, 5 DIV, 6 SHL, 7 SHR, 8 AND, 9 OR, 10 INV(~a), 11 NAND, 12 NOR, 13 XOR, 14 XNOR, 15 BUF(a). All logic ops are bitwise.
- Width rules: all results are zero-extended to 2*WIDTH unless stated otherwise.
  - ADD/INC: out[WIDTH] = carry.
  - SUB/DEC: out[WIDTH-1:0] = modulo difference; out[WIDTH] = borrow (1 when a<b, or when a==0 for DEC).
  - SHL: out[WIDTH:0] = {a,1'b0}. SHR: a>>1.
  - MUL: full 2*WIDTH product.
  - DIV: out = {remainder, quotient}.
- FSM states:
  - IDLE: in_ready=1. On accepting a single-cycle op (anything except MUL, or DIV with b!=0), the result is registered at that same edge. out_valid=1 for the following cycle and FSM stays IDLE. Latency is 1 and throughput is 1 per cycle; back-to-back transfers are legal.
  - MUL/DIV with b!=0 accepted: latch operands, load counter=WIDTH, go to BUSY. in_ready=0 from the next cycle.
  - BUSY: one shift-add or restore step per cycle; counter decrements. in_valid is ignored. When counter reaches 0, register the result, set out_valid=1, set in_ready=1, and return to IDLE. Total latency is WIDTH+1 cycles from the accept edge to the out_valid cycle.
  - DIV with b==0: no BUSY. Latency 1. out = {a, all-ones quotient}, div_by_zero=1.
- Flags update only together with out_valid; they hold otherwise. div_by_zero clears on the next non-faulting result.
- out_valid has no backpressure; the consumer must capture it on the pulse.
- Unsigned arithmetic only; no overflow flag beyond carry/borrow in bit WIDTH.

Test Plan:
- WIDTH=8, ADD a=200 b=100 -> one cycle after accept: out=0x012C, out_valid=1 for exactly 1 cycle, zero=0.
- Back-to-back SUB a=5 b=10, then XOR a=0xAA b=0xAA on consecutive cycles -> out=0x01FB (borrow set), then out=0x0000 with zero=1, on consecutive cycles.
- MUL a=255 b=255 -> in_ready low for 8 cycles; out=0xFE01 with out_valid 9 cycles after accept. A second in_valid held during BUSY is not accepted until in_ready returns.
- DIV a=200 b=7 -> out=0x041C (rem 4, quot 28) after 9 cycles. DIV a=13 b=0 -> out=0x0DFF, div_by_zero=1, latency 1.
- Assert rst at cycle 4 of a MUL -> outputs immediately return to reset values; no out_valid; the next ADD a=1 b=1 after deassertion yields out=0x0002.
- Sweep a,b over 0..15 and all 16 commands (WIDTH=8), then WIDTH=16 spot checks (MUL 0xFFFF*0xFFFF=0xFFFE0001, latency 17) -> all outputs match the reference model.
